// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared constants and strobe-merge helper for the dual-port BRAM
package bram_pkg;

  localparam int RDW_READ_FIRST   = 0;
  localparam int RDW_WRITE_FIRST  = 1;
  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_DATA_WIDTH   = 256;
  localparam int MAX_STRB_WIDTH   = 256;

  // Callers zero-extend into the max width and cast the result back down.
  function automatic logic [MAX_DATA_WIDTH-1:0] merge_word(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_STRB_WIDTH-1:0] strb,
    input int                        lane_w
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
      merged[b] = strb[b / lane_w] ? new_word[b] : old_word[b];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// rtl/bram_rd_pipe.sv - per-port read data/valid shift pipeline with hold-on-invalid output
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  // Each stage only loads on a valid word, so every stage (and the output) holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/bram_dp_pipelined.sv
// rtl/bram_dp_pipelined.sv - true dual-port BRAM with pipelined reads, RDW modes and collision flag
module bram_dp_pipelined
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 2,
  parameter int RDW_MODE     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdena,
  input  logic                  wrena,
  input  logic [STRB_WIDTH-1:0] wrstrba,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  rvalida,
  input  logic                  rdenb,
  input  logic                  wrenb,
  input  logic [STRB_WIDTH-1:0] wrstrbb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  rvalidb,
  output logic                  coll
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_W = DATA_WIDTH / STRB_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..%0d", MAX_READ_LATENCY);
  end
  if (DATA_WIDTH % STRB_WIDTH != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of STRB_WIDTH and at most %0d", MAX_DATA_WIDTH);
  end

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic                  wr_a, wr_b;
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;
  logic [DATA_WIDTH-1:0] s0_data_a, s0_data_b;
  logic                  s0_valid_a, s0_valid_b;

  assign wr_a = wrena & rst_n;
  assign wr_b = wrenb & rst_n;

  // Port A lanes are written last so they override port B on a same-address dual write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (wr_b && wrstrbb[i]) begin
        ram[addrb][i*LANE_W +: LANE_W] <= dinb[i*LANE_W +: LANE_W];
      end
      if (wr_a && wrstrba[i]) begin
        ram[addra][i*LANE_W +: LANE_W] <= dina[i*LANE_W +: LANE_W];
      end
    end
  end

  // Only the port's own write is merged; a cross-port write is never forwarded.
  always_comb begin
    rd_word_a = ram[addra];
    rd_word_b = ram[addrb];
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      if (wrena) begin
        rd_word_a = DATA_WIDTH'(merge_word(MAX_DATA_WIDTH'(ram[addra]), MAX_DATA_WIDTH'(dina),
                                           MAX_STRB_WIDTH'(wrstrba), LANE_W));
      end
      if (wrenb) begin
        rd_word_b = DATA_WIDTH'(merge_word(MAX_DATA_WIDTH'(ram[addrb]), MAX_DATA_WIDTH'(dinb),
                                           MAX_STRB_WIDTH'(wrstrbb), LANE_W));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_data_a  <= '0;
      s0_data_b  <= '0;
      s0_valid_a <= 1'b0;
      s0_valid_b <= 1'b0;
      coll       <= 1'b0;
    end else begin
      s0_valid_a <= rdena;
      s0_valid_b <= rdenb;
      if (rdena) begin
        s0_data_a <= rd_word_a;
      end
      if (rdenb) begin
        s0_data_b <= rd_word_b;
      end
      coll <= wrena && wrenb && (addra == addrb);
    end
  end

  if (READ_LATENCY == 1) begin : g_no_pipe
    assign douta   = s0_data_a;
    assign rvalida = s0_valid_a;
    assign doutb   = s0_data_b;
    assign rvalidb = s0_valid_b;
  end else begin : g_pipe
    bram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (READ_LATENCY - 1)
    ) u_pipe_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (s0_data_a),
      .in_valid  (s0_valid_a),
      .out_data  (douta),
      .out_valid (rvalida)
    );

    bram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (READ_LATENCY - 1)
    ) u_pipe_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (s0_data_b),
      .in_valid  (s0_valid_b),
      .out_data  (doutb),
      .out_valid (rvalidb)
    );
  end

endmodule

// File: tb/tb_bram_dp_pipelined.sv
// tb/tb_bram_dp_pipelined.sv - scoreboard bench for bram_dp_pipelined
module tb_bram_dp_pipelined;
  parameter int READ_LATENCY = 2;
  parameter int RDW_MODE     = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdena, wrena, rdenb, wrenb;
  logic [3:0]  wrstrba, wrstrbb;
  logic [9:0]  addra, addrb;
  logic [31:0] dina, dinb, douta, doutb;
  logic        rvalida, rvalidb, coll;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t     q_a[$];
  rd_exp_t     q_b[$];
  int          cyc      = 0;
  int          coll_due = -100;
  int          checks   = 0;
  int          errors   = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] last_a   = '0;
  logic [31:0] last_b   = '0;
  logic [31:0] vals [4];

  bram_dp_pipelined #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (10),
    .STRB_WIDTH   (4),
    .READ_LATENCY (READ_LATENCY),
    .RDW_MODE     (RDW_MODE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdena   (rdena),
    .wrena   (wrena),
    .wrstrba (wrstrba),
    .addra   (addra),
    .dina    (dina),
    .douta   (douta),
    .rvalida (rvalida),
    .rdenb   (rdenb),
    .wrenb   (wrenb),
    .wrstrbb (wrstrbb),
    .addrb   (addrb),
    .dinb    (dinb),
    .doutb   (doutb),
    .rvalidb (rvalidb),
    .coll    (coll)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon_port(input bit pb, input logic v, input logic [31:0] d);
    rd_exp_t e;
    string   nm;
    nm = pb ? "port_b" : "port_a";
    if (!rst_n) begin
      checks++;
      if (v !== 1'b0 || d !== 32'h0) begin
        errors++;
        $display("FAIL %s_in_reset got dout=%h rvalid=%b exp dout=0 rvalid=0", nm, d, v);
      end
      if (pb) last_b = '0; else last_a = '0;
      return;
    end
    while ((pb ? q_b.size() : q_a.size()) > 0) begin
      e = pb ? q_b[0] : q_a[0];
      if (e.due >= cyc) break;
      checks++;
      errors++;
      $display("FAIL %s_missing_rvalid got none exp %h at cycle %0d", nm, e.data, e.due);
      if (pb) void'(q_b.pop_front()); else void'(q_a.pop_front());
    end
    if (v === 1'b1) begin
      checks++;
      if ((pb ? q_b.size() : q_a.size()) == 0) begin
        errors++;
        $display("FAIL %s_unexpected_rvalid got %h at cycle %0d exp no read", nm, d, cyc);
      end else begin
        e = pb ? q_b.pop_front() : q_a.pop_front();
        if (d !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL %s_read got %h at cycle %0d exp %h at cycle %0d", nm, d, cyc, e.data, e.due);
        end
      end
      if (pb) last_b = d; else last_a = d;
    end else begin
      checks++;
      if (d !== (pb ? last_b : last_a)) begin
        errors++;
        $display("FAIL %s_hold got %h exp %h", nm, d, pb ? last_b : last_a);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_port(1'b0, rvalida, douta);
      mon_port(1'b1, rvalidb, doutb);
      checks++;
      if (coll !== (cyc == coll_due)) begin
        errors++;
        $display("FAIL coll at cycle %0d got %b exp %b", cyc, coll, cyc == coll_due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rdena = 1'b0; wrena = 1'b0; wrstrba = '0;
    rdenb = 1'b0; wrenb = 1'b0; wrstrbb = '0;
  endtask

  task automatic push_rd(input bit pb, input logic [31:0] exp_data);
    rd_exp_t e;
    e.data = exp_data;
    e.due  = cyc + READ_LATENCY;
    if (pb) q_b.push_back(e); else q_a.push_back(e);
  endtask

  task automatic set_wr(input bit pb, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    if (pb) begin wrenb = 1'b1; addrb = a; dinb = d; wrstrbb = s; end
    else    begin wrena = 1'b1; addra = a; dina = d; wrstrba = s; end
  endtask

  task automatic set_rd(input bit pb, input logic [9:0] a, input logic [31:0] exp_data);
    if (pb) begin rdenb = 1'b1; addrb = a; end
    else    begin rdena = 1'b1; addra = a; end
    push_rd(pb, exp_data);
  endtask

  task automatic wr(input bit pb, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    set_wr(pb, a, d, s);
    tick();
  endtask

  task automatic rd(input bit pb, input logic [9:0] a, input logic [31:0] exp_data);
    set_rd(pb, a, exp_data);
    tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rdena = 1'b0; wrena = 1'b0; wrstrba = '0; addra = '0; dina = '0;
    rdenb = 1'b0; wrenb = 1'b0; wrstrbb = '0; addrb = '0; dinb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    chk("reset_douta", douta, 32'h0);
    chk("reset_doutb", doutb, 32'h0);
    chk("reset_rvalida", {31'b0, rvalida}, 32'h0);
    chk("reset_rvalidb", {31'b0, rvalidb}, 32'h0);
    chk("reset_coll", {31'b0, coll}, 32'h0);
    repeat (10) tick();

    // latency and back-to-back reads
    wr(1'b0, 10'h010, 32'hDEADBEEF, 4'hF);
    wr(1'b1, 10'h011, 32'h01234567, 4'hF);
    wr(1'b0, 10'h012, 32'h89ABCDEF, 4'hF);
    wr(1'b1, 10'h013, 32'h55AA55AA, 4'hF);
    rd(1'b1, 10'h010, 32'hDEADBEEF);
    repeat (5) tick();
    vals[0] = 32'hDEADBEEF; vals[1] = 32'h01234567;
    vals[2] = 32'h89ABCDEF; vals[3] = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) begin
      set_rd(1'b1, 10'h010 + 10'(i), vals[i]);
      set_rd(1'b0, 10'h013 - 10'(i), vals[3-i]);
      tick();
    end

    // byte strobes
    wr(1'b0, 10'h020, 32'h11223344, 4'hF);
    wr(1'b0, 10'h020, 32'hAABBCCDD, 4'b0101);
    wr(1'b1, 10'h020, 32'hFFFFFFFF, 4'b0000);
    rd(1'b0, 10'h020, 32'h11BB33DD);

    // same-port and cross-port read-during-write
    wr(1'b0, 10'h030, 32'h00000000, 4'hF);
    set_rd(1'b0, 10'h030, (RDW_MODE == 1) ? 32'hCAFEF00D : 32'h00000000);
    set_wr(1'b0, 10'h030, 32'hCAFEF00D, 4'hF);
    tick();
    rd(1'b0, 10'h030, 32'hCAFEF00D);
    set_wr(1'b0, 10'h030, 32'h12345678, 4'hF);
    set_rd(1'b1, 10'h030, 32'hCAFEF00D);
    tick();
    rd(1'b1, 10'h030, 32'h12345678);

    // dual-write collision with lane arbitration
    wr(1'b1, 10'h040, 32'h00000000, 4'hF);
    set_wr(1'b0, 10'h040, 32'h11111111, 4'b0011);
    set_wr(1'b1, 10'h040, 32'h22222222, 4'b0110);
    coll_due = cyc + 1;
    tick();
    rd(1'b0, 10'h040, 32'h00221111);
    set_wr(1'b0, 10'h050, 32'hA5A5A5A5, 4'hF);
    set_wr(1'b1, 10'h051, 32'h5A5A5A5A, 4'hF);
    tick();
    set_rd(1'b0, 10'h051, 32'h5A5A5A5A);
    set_rd(1'b1, 10'h050, 32'hA5A5A5A5);
    tick();
    repeat (6) tick();

    // reset while a read is in flight
    rd(1'b0, 10'h010, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = q_a.size() - 1; i >= 0; i--) begin
      if (q_a[i].due > cyc) q_a.delete(i);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("midreset_douta", douta, 32'h0);
    chk("midreset_rvalida", {31'b0, rvalida}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) tick();
    rd(1'b0, 10'h010, 32'hDEADBEEF);
    rd(1'b1, 10'h040, 32'h00221111);

    for (int i = 0; i < 20 && (q_a.size() + q_b.size()) > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ((q_a.size() + q_b.size()) != 0) begin
      errors++;
      $display("FAIL drain got %0d pending reads exp 0", q_a.size() + q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_dp_pipelined.md
Name: bram_dp_pipelined

Overview:
- Parametrised true-dual-port block RAM, successor to the single-cycle read-enable BRAM.
- Adds a configurable read latency with output pipeline and per-port read-valid tracking.
- Adds selectable read-during-write semantics and simultaneous read+write on one port.
- Defined arbitration and a collision flag for same-address writes from both ports; used as coefficient/activation storage behind the KAN compute datapath.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of STRB_WIDTH
ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH
STRB_WIDTH, DATA_WIDTH/8, byte-lane write strobes per word
READ_LATENCY, 2, cycles from rden sample to rdata/rvalid; legal 1..4, elaboration error otherwise
RDW_MODE, 0, same-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (merged new data)

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
rdena  in  1  port A read request
wrena  in  1  port A write request
wrstrba  in  STRB_WIDTH  port A byte write strobes
addra  in  ADDR_WIDTH  port A address
dina  in  DATA_WIDTH  port A write data
douta  out  DATA_WIDTH  port A read data
rvalida  out  1  port A read data valid, one-cycle pulse per accepted read
rdenb, wrenb, wrstrbb, addrb, dinb, doutb, rvalidb  (port B, same widths and meanings as port A)
coll  out  1  one-cycle pulse: both ports wrote the same address in the same cycle

Behaviour:
- Reset: rst_n low asynchronously clears douta, doutb, rvalida, rvalidb, coll and all pipeline/valid stages to 0. Memory array is not reset and keeps its contents.
- While rst_n is low, reads and writes are ignored. Reset mid-read drops in-flight reads: no rvalid pulse follows.
- Write: when wrenX=1, each lane i with wrstrbX[i]=1 updates ram[addrX][8i+:8]. Lanes with strobe 0 are untouched. wrenX=1 with strobe 0 is a no-op.
- Read: a read is accepted every cycle rdenX=1, fully pipelined with no back-pressure. Data is sampled at cycle T and presented with rvalidX=1 at cycle T+READ_LATENCY.
- Output hold: doutX changes only on cycles where rvalidX=1, and holds the last read word otherwise.
- Simultaneous rdenX and wrenX on one port is legal; both are performed.
  - Same address, READ_FIRST: the read returns pre-write data.
  - Same address, WRITE_FIRST: the read returns the merged word (strobed lanes = dinX, other lanes = old data).
- Cross-port read/write to the same address in the same cycle: the reader always gets the old data, regardless of RDW_MODE.
- Dual write, same address, same cycle:
  - Lanes strobed by both ports take port A data.
  - Lanes strobed by one port only take that port's data.
  - coll pulses high in cycle T+1.
  - coll is not raised for differing addresses or when either port has wren=0.
- Address range is full power-of-two, so there is no out-of-range case and no wrap logic.
- Pipeline: stage 0 registers the memory read (and WRITE_FIRST merge); stages 1..READ_LATENCY-1 are plain registers. The valid bit shifts in lockstep with its data.

Decomposition:
- Package bram_pkg: RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, MAX_READ_LATENCY=4, and a function computing the strobe-merged word (old, new, strb).
- Sub-module bram_rd_pipe: per-port data+valid shift pipeline of depth READ_LATENCY-1 with async active-low reset and hold-on-invalid output. Instantiated once per port.
- The top level holds the memory array, write arbitration, the RDW merge and the collision detector.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, release -> douta=doutb=0, rvalida=rvalidb=coll=0; issue no requests for 10 cycles -> rvalids stay 0.
- Latency sweep, READ_LATENCY in {1,2,4}: write 0xDEADBEEF to A:0x010, read B:0x010 at cycle T -> doutb=0xDEADBEEF with rvalidb=1 exactly at T+READ_LATENCY; back-to-back reads of 0x010..0x013 -> 4 consecutive valid cycles in order.
- Byte strobes: preload 0x11223344 at 0x020, A writes 0xAABBCCDD with strb=4'b0101 -> read returns 0x11BB33DD.
- RDW: preload 0x00000000 at 0x030, A reads and writes 0xCAFEF00D (strb=4'hF) at 0x030 in the same cycle -> READ_FIRST returns 0x00000000, WRITE_FIRST returns 0xCAFEF00D; a subsequent read returns 0xCAFEF00D in both modes.
- Collision: A writes 0x11111111 strb=4'b0011 and B writes 0x22222222 strb=4'b0110 to 0x040 in one cycle -> coll=1 next cycle only; read gives 0x0022_1111 over old 0x00000000 lanes (lane0=11, lane1=11 from A, lane2=22, lane3 unchanged).
- Reset mid-flight: READ_LATENCY=4, issue read, assert rst_n low 2 cycles later -> no rvalid pulse, dout=0; memory contents intact on the post-reset read.
